// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for the shared RAM port arbiter.
// Per-requester fields are flattened, requester i in slice i.
interface ram_port_arbiter_if #(
    parameter int num_req        = 4,
    parameter int address_length = 10,
    parameter int word_length    = 64
);
    logic [num_req-1:0]                req;
    logic [num_req-1:0]                wren;
    logic [num_req-1:0]                lock;
    logic [num_req*address_length-1:0] address;
    logic [num_req*word_length-1:0]    wdata;
    logic [num_req-1:0]                gnt;
    logic [num_req-1:0]                rsp_valid;
    logic [word_length-1:0]            rdata;

    modport master (
        output req, wren, lock, address, wdata,
        input  gnt, rsp_valid, rdata
    );

    modport slave (
        input  req, wren, lock, address, wdata,
        output gnt, rsp_valid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing one RAM port
// among num_req requesters; routes the 1-cycle RAM output back.
module ram_port_arbiter #(
    parameter int num_req        = 4,
    parameter int address_length = 10,
    parameter int word_length    = 64,
    parameter int max_lock       = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    ram_port_arbiter_if.slave         bus,
    output logic [address_length-1:0] ram_address_o,
    output logic [word_length-1:0]    ram_data_o,
    output logic                      ram_wren_o,
    input  logic [word_length-1:0]    ram_q_i
);

    localparam int PW = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int CW = $clog2(max_lock + 1);

    localparam logic [0:0] ARB    = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [num_req-1:0] rsp_q;

    logic [num_req-1:0] gnt;
    logic [PW-1:0]      rr_idx;
    logic [PW-1:0]      sel;
    logic               found;
    logic               take_lock;

    function automatic logic [PW-1:0] wrap_add(
        input logic [PW-1:0] base,
        input int            k
    );
        int s;
        s = int'(base) + k;
        if (s >= num_req)
            s = s - num_req;
        return PW'(s);
    endfunction

    // First requester at or after ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        rr_idx = ptr_q;
        for (int k = 0; k < num_req; k++) begin
            if (!found && bus.req[wrap_add(ptr_q, k)]) begin
                found  = 1'b1;
                rr_idx = wrap_add(ptr_q, k);
            end
        end
    end

    assign take_lock = (state_q == LOCKED)
                     && bus.req[owner_q]
                     && (cnt_q < CW'(max_lock));

    always_comb begin
        gnt     = '0;
        sel     = '0;
        ptr_d   = ptr_q;
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!reset_i) begin
            unique case (1'b1)
                take_lock: begin
                    sel          = owner_q;
                    gnt[owner_q] = 1'b1;
                    cnt_d        = cnt_q + CW'(1);
                    state_d      = bus.lock[owner_q] ? LOCKED : ARB;
                end
                (found && !take_lock): begin
                    sel         = rr_idx;
                    gnt[rr_idx] = 1'b1;
                    ptr_d       = wrap_add(rr_idx, 1);
                    if (bus.lock[rr_idx]) begin
                        state_d = LOCKED;
                        owner_d = rr_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // sel falls back to requester 0 when idle, keeping address/data defined.
    assign ram_address_o = bus.address[int'(sel)*address_length +: address_length];
    assign ram_data_o    = bus.wdata[int'(sel)*word_length +: word_length];
    assign ram_wren_o    = (|gnt) & bus.wren[sel];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rsp_q   <= gnt;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_q;
    assign bus.rdata     = ram_q_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with an attached RAM model.
// Directed scenarios followed by randomized traffic.
module tb_ram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(
        .num_req(N), .address_length(AW), .word_length(DW)
    ) bus ();

    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          ram_wren;

    ram_port_arbiter #(
        .num_req(N), .address_length(AW),
        .word_length(DW), .max_lock(ML)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .bus          (bus),
        .ram_address_o(ram_address),
        .ram_data_o   (ram_data),
        .ram_wren_o   (ram_wren),
        .ram_q_i      (ram_q)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return {32'hC0DE_0000 + 32'(a), 32'(a * 7 + 3)};
    endfunction

    // RAM model: registered output, write returns written data.
    logic [DW-1:0] mem [1<<AW];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
            ram_q  <= '0;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
            ram_q            <= ram_data;
        end else begin
            ram_q <= mem[ram_address];
        end
    end

    typedef struct {
        int          stamp;
        int          idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [1<<AW];

    int m_next   = 0;
    int m_holder = -1;
    int m_streak = 0;
    int last_win = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t          e;
        logic [N-1:0]  oh;
        if (bus.rsp_valid !== '0) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].stamp != cyc - 1) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d rsp_valid=%b required=none",
                         cyc, bus.rsp_valid);
            end else begin
                e  = sbq.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                if (bus.rsp_valid !== oh || bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got v=%b d=%h required v=%b d=%h",
                             cyc, bus.rsp_valid, bus.rdata, oh, e.data);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].stamp < cyc) begin
            checks++;
            errors++;
            e = sbq.pop_front();
            $display("FAIL rsp_missing cyc=%0d got v=0 required idx=%0d",
                     cyc, e.idx);
        end
    end

    // Reference: bounded-lock round robin in plain integer terms.
    task automatic evaluate(input int dir);
        int           w;
        int           c;
        int           a;
        logic [N-1:0] expg;
        logic [N-1:0] dexp;
        w = -1;
        if (reset) begin
            m_next   = 0;
            m_holder = -1;
            m_streak = 0;
        end else if (m_holder >= 0 && bus.req[m_holder] && m_streak < ML) begin
            w = m_holder;
            m_streak++;
            if (!bus.lock[w]) m_holder = -1;
        end else begin
            m_holder = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_next + k) % N;
                if (w < 0 && bus.req[c]) w = c;
            end
            if (w >= 0) begin
                m_next = (w + 1) % N;
                if (bus.lock[w]) begin
                    m_holder = w;
                    m_streak = 1;
                end
            end
        end
        expg = '0;
        if (w >= 0) expg[w] = 1'b1;
        checks++;
        if (bus.gnt !== expg) begin
            errors++;
            $display("FAIL gnt cyc=%0d got %b required %b", cyc, bus.gnt, expg);
        end
        if (dir != -2) begin
            dexp = '0;
            if (dir >= 0) dexp[dir] = 1'b1;
            checks++;
            if (bus.gnt !== dexp) begin
                errors++;
                $display("FAIL gnt_directed cyc=%0d got %b required %b",
                         cyc, bus.gnt, dexp);
            end
        end
        checks++;
        if (w >= 0) begin
            a = int'(bus.address[w*AW +: AW]);
            if (ram_address !== bus.address[w*AW +: AW]
                || ram_wren !== bus.wren[w]
                || (bus.wren[w] && ram_data !== bus.wdata[w*DW +: DW])) begin
                errors++;
                $display("FAIL ram_drive cyc=%0d got a=%0d we=%b required a=%0d we=%b",
                         cyc, ram_address, ram_wren, a, bus.wren[w]);
            end
            if (bus.wren[w]) begin
                ref_mem[a] = bus.wdata[w*DW +: DW];
                sbq.push_back('{cyc, w, bus.wdata[w*DW +: DW]});
            end else begin
                sbq.push_back('{cyc, w, ref_mem[a]});
            end
        end else begin
            if (ram_wren !== 1'b0 || ram_address !== bus.address[AW-1:0]) begin
                errors++;
                $display("FAIL idle_drive cyc=%0d got we=%b a=%0d required we=0 a=%0d",
                         cyc, ram_wren, ram_address, bus.address[AW-1:0]);
            end
        end
        last_win = w;
    endtask

    task automatic tick(input int dir);
        @(negedge clk);
        evaluate(dir);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] r, input logic [N-1:0] l,
                           input logic [N-1:0] w);
        bus.req  = r;
        bus.lock = l;
        bus.wren = w;
    endtask

    task automatic set_fields(input int i, input int a, input logic [DW-1:0] d);
        bus.address[i*AW +: AW] = AW'(a);
        bus.wdata[i*DW +: DW]   = d;
    endtask

    logic [N-1:0] pend;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        reset       = 1'b1;
        bus.req     = '0;
        bus.lock    = '0;
        bus.wren    = '0;
        bus.address = '0;
        bus.wdata   = '0;
        tick(-1);
        tick(-1);
        reset = 1'b0;

        // Round robin over four reads.
        for (int i = 0; i < N; i++) set_fields(i, i, '0);
        set_req(4'b1111, 4'b0000, 4'b0000);
        tick(0); tick(1); tick(2); tick(3); tick(0);

        // Write then read-back of the same address.
        set_fields(2, 5, 64'hDEAD_BEEF);
        set_req(4'b0100, 4'b0000, 4'b0100);
        tick(2);
        set_fields(0, 5, '0);
        set_req(4'b0001, 4'b0000, 4'b0000);
        tick(0);
        set_req(4'b0000, 4'b0000, 4'b0000);
        tick(-1);

        // Lock bounded to max_lock, then re-lock after one other grant.
        set_req(4'b1010, 4'b0010, 4'b0000);
        tick(1); tick(1); tick(1); tick(1); tick(3); tick(1);

        // Idle: no grants, pointer kept.
        set_req(4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) tick(-1);

        // Lock dropped on the second access.
        set_req(4'b0010, 4'b0010, 4'b0000);
        tick(1);
        set_req(4'b1110, 4'b0000, 4'b0000);
        tick(1);
        set_req(4'b1100, 4'b0000, 4'b0000);
        tick(2);
        tick(3);

        // Reset right after a grant.
        set_req(4'b1000, 4'b0000, 4'b0000);
        tick(3);
        reset = 1'b1;
        set_req(4'b1111, 4'b0000, 4'b0000);
        tick(-1);
        tick(-1);
        reset = 1'b0;
        tick(0);

        // Randomized traffic with held requests and withdrawals.
        set_req(4'b0000, 4'b0000, 4'b0000);
        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    bus.wren[i] = 1'($urandom_range(0, 1));
                    set_fields(i, int'($urandom_range(0, 15)),
                               {$urandom, $urandom});
                end
                bus.lock[i] = 1'($urandom_range(0, 1));
            end
            reset   = ($urandom_range(0, 399) == 0);
            bus.req = pend;
            tick(-2);
            if (last_win >= 0) pend[last_win] = 1'b0;
        end

        reset = 1'b0;
        set_req(4'b0000, 4'b0000, 4'b0000);
        tick(-2);
        tick(-2);
        tick(-2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
